// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM port arbiter
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        CMD,
        ACCEPT,
        BURST,
        DRAIN
    } arb_state_e;

    localparam logic PORT_RD = 1'b0;
    localparam logic PORT_WR = 1'b1;
    localparam int   LEN_W   = 8;

endpackage

// File: rtl/sdram_port_arbiter_arb_grant.sv
// rtl/sdram_port_arbiter_arb_grant.sv - port priority with port-1 starvation guard
module arb_grant
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic p0_req,
    input  logic p1_req,
    input  logic grant_en,
    output logic grant_port
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    // Port 0 wins until port 1 has been passed over STARVE_LIMIT times in a row
    always_comb begin
        starved      = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) && p1_req;
        grant_port   = ((p1_req && !p0_req) || starved) ? PORT_WR : PORT_RD;
        starve_cnt_d = starve_cnt_q;
        if (!p1_req) begin
            starve_cnt_d = '0;
        end else if (grant_en) begin
            if (grant_port == PORT_WR) begin
                starve_cnt_d = '0;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares one SDRAM controller port between a reader and a writer
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = 21,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int ACC_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [LEN_W-1:0]  p0_len,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [LEN_W-1:0]  p1_len,
    output logic              p1_ack,
    output logic              p1_done,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_wnext,
    input  logic              sdrc_init_done,
    input  logic              sdrc_busy_n,
    input  logic              sdrc_rd_valid,
    input  logic [DATA_W-1:0] sdrc_rdata,
    output logic              sdrc_wr_n,
    output logic              sdrc_rd_n,
    output logic [ADDR_W-1:0] sdrc_addr,
    output logic [LEN_W-1:0]  sdrc_data_len,
    output logic [1:0]        sdrc_dqm,
    output logic [DATA_W-1:0] sdrc_wdata,
    output logic              timeout_err
);

    localparam int TMR_W = $clog2(ACC_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [8:0]        beat_q, beat_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [LEN_W-1:0]  wleft_q, wleft_d;
    logic              wnext_dly_q, wnext_dly_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic grant_en;
    logic grant_port;
    logic cmd_rd;
    logic cmd_wr;
    logic last_beat;

    assign grant_en  = (state_q == IDLE) && sdrc_busy_n && sdrc_init_done && (p0_req || p1_req);
    assign cmd_rd    = (state_q == CMD) && (owner_q == PORT_RD);
    assign cmd_wr    = (state_q == CMD) && (owner_q == PORT_WR);
    assign last_beat = (beat_q == {1'b0, len_q});

    arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_grant (
        .clk        (clk),
        .reset      (reset),
        .p0_req     (p0_req),
        .p1_req     (p1_req),
        .grant_en   (grant_en),
        .grant_port (grant_port)
    );

    // Command sequencing: grant, strobe, wait for acceptance, move the burst, drain
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        timer_d       = timer_q;
        wleft_d       = (wleft_q != '0) ? wleft_q - LEN_W'(1) : wleft_q;
        wnext_dly_d   = p1_wnext;
        wdata_d       = wnext_dly_q ? p1_wdata : wdata_q;
        rvalid_d      = 1'b0;
        rdata_d       = rdata_q;
        p0_done_d     = 1'b0;
        p1_done_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            INIT: begin
                if (sdrc_init_done) state_d = IDLE;
            end
            IDLE: begin
                if (grant_en) begin
                    state_d = CMD;
                    owner_d = grant_port;
                    addr_d  = (grant_port == PORT_WR) ? p1_addr : p0_addr;
                    len_d   = (grant_port == PORT_WR) ? p1_len : p0_len;
                end
            end
            CMD: begin
                state_d = ACCEPT;
                timer_d = '0;
                beat_d  = '0;
                if (owner_q == PORT_WR) wleft_d = len_q;
            end
            ACCEPT: begin
                if (!sdrc_busy_n) begin
                    state_d = BURST;
                end else if (timer_q == TMR_W'(ACC_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                    p0_done_d     = (owner_q == PORT_RD);
                    p1_done_d     = (owner_q == PORT_WR);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            BURST: begin
                if (owner_q == PORT_RD) begin
                    if (sdrc_rd_valid) begin
                        rvalid_d = 1'b1;
                        rdata_d  = sdrc_rdata;
                        beat_d   = beat_q + 9'd1;
                        if (last_beat) begin
                            p0_done_d = 1'b1;
                            state_d   = DRAIN;
                        end
                    end
                end else begin
                    beat_d = beat_q + 9'd1;
                    if (last_beat) begin
                        p1_done_d = 1'b1;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sdrc_busy_n) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
        // Losing the controller abandons the transfer silently
        if (!sdrc_init_done) begin
            state_d   = INIT;
            wleft_d   = '0;
            rvalid_d  = 1'b0;
            p0_done_d = 1'b0;
            p1_done_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT;
            owner_q       <= PORT_RD;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            timer_q       <= '0;
            wleft_q       <= '0;
            wnext_dly_q   <= 1'b0;
            wdata_q       <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            p0_done_q     <= 1'b0;
            p1_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            timer_q       <= timer_d;
            wleft_q       <= wleft_d;
            wnext_dly_q   <= wnext_dly_d;
            wdata_q       <= wdata_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            p0_done_q     <= p0_done_d;
            p1_done_q     <= p1_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign sdrc_rd_n     = !cmd_rd;
    assign sdrc_wr_n     = !cmd_wr;
    assign p0_ack        = cmd_rd;
    assign p1_ack        = cmd_wr;
    assign p1_wnext      = cmd_wr || (wleft_q != '0);
    assign sdrc_addr     = addr_q;
    assign sdrc_data_len = len_q;
    assign sdrc_dqm      = 2'b00;
    assign sdrc_wdata    = wdata_q;
    assign p0_rvalid     = rvalid_q;
    assign p0_rdata      = rdata_q;
    assign p0_done       = p0_done_q;
    assign p1_done       = p1_done_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0;
    logic [20:0] p0_addr = '0;
    logic [7:0]  p0_len = '0;
    logic        p0_ack, p0_rvalid, p0_done;
    logic [15:0] p0_rdata;
    logic        p1_req = 1'b0;
    logic [20:0] p1_addr = '0;
    logic [7:0]  p1_len = '0;
    logic        p1_ack, p1_done, p1_wnext;
    logic [15:0] p1_wdata = '0;
    logic        sdrc_init_done = 1'b0;
    logic        sdrc_busy_n = 1'b1;
    logic        sdrc_rd_valid = 1'b0;
    logic [15:0] sdrc_rdata = '0;
    logic        sdrc_wr_n, sdrc_rd_n;
    logic [20:0] sdrc_addr;
    logic [7:0]  sdrc_data_len;
    logic [1:0]  sdrc_dqm;
    logic [15:0] sdrc_wdata;
    logic        timeout_err;

    int vectors = 0;
    int miscompares = 0;

    beat_t exp_rd_q[$];
    logic  exp_gnt_q[$];

    int rd_lo_cnt = 0, wr_lo_cnt = 0, wnext_cnt = 0, rv_cnt = 0;
    int ack_cnt = 0, p0_done_cnt = 0, p1_done_cnt = 0;

    logic        m_active = 1'b0, m_is_rd = 1'b0, m_hang = 1'b0;
    int          m_cnt = 0, m_len = 0;
    logic [15:0] m_base = '0;

    logic        wnext_seen = 1'b0;
    logic [15:0] wbase = '0;
    int          wbeat = 0;

    sdram_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .p0_req         (p0_req),
        .p0_addr        (p0_addr),
        .p0_len         (p0_len),
        .p0_ack         (p0_ack),
        .p0_rvalid      (p0_rvalid),
        .p0_rdata       (p0_rdata),
        .p0_done        (p0_done),
        .p1_req         (p1_req),
        .p1_addr        (p1_addr),
        .p1_len         (p1_len),
        .p1_ack         (p1_ack),
        .p1_done        (p1_done),
        .p1_wdata       (p1_wdata),
        .p1_wnext       (p1_wnext),
        .sdrc_init_done (sdrc_init_done),
        .sdrc_busy_n    (sdrc_busy_n),
        .sdrc_rd_valid  (sdrc_rd_valid),
        .sdrc_rdata     (sdrc_rdata),
        .sdrc_wr_n      (sdrc_wr_n),
        .sdrc_rd_n      (sdrc_rd_n),
        .sdrc_addr      (sdrc_addr),
        .sdrc_data_len  (sdrc_data_len),
        .sdrc_dqm       (sdrc_dqm),
        .sdrc_wdata     (sdrc_wdata),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int which);
        case (which)
            0: return p0_ack;
            1: return p1_ack;
            2: return p0_done;
            default: return p1_done;
        endcase
    endfunction

    task automatic wait_pulse(input int which, input int lim, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pick(which) && n < lim);
        check({tag, "_seen"}, 32'(pick(which)), 32'd1);
    endtask

    // Expected read beats for a burst: the controller model returns base^addr plus beat index
    task automatic push_read(input logic [20:0] addr, input int len);
        for (int i = 0; i <= len; i++) begin
            beat_t b;
            b.data = (16'hA000 ^ addr[15:0]) + 16'(i);
            b.last = (i == len);
            exp_rd_q.push_back(b);
        end
    endtask

    // Controller model: accepts a strobe, drops busy_n, returns read beats, then goes idle
    always @(negedge clk) begin
        sdrc_rd_valid = 1'b0;
        if (reset) begin
            sdrc_busy_n = 1'b1;
            m_active    = 1'b0;
        end else if (m_active) begin
            m_cnt++;
            if (m_is_rd && m_cnt >= 2 && m_cnt <= m_len + 2) begin
                sdrc_rd_valid = 1'b1;
                sdrc_rdata    = m_base + 16'(m_cnt - 2);
            end
            if (m_cnt >= m_len + 4) begin
                sdrc_busy_n = 1'b1;
                m_active    = 1'b0;
            end
        end else if (!m_hang && (!sdrc_rd_n || !sdrc_wr_n)) begin
            sdrc_busy_n = 1'b0;
            m_active    = 1'b1;
            m_cnt       = 0;
            m_is_rd     = !sdrc_rd_n;
            m_len       = int'(sdrc_data_len);
            m_base      = 16'hA000 ^ sdrc_addr[15:0];
        end
    end

    // Write requester: presents the next word in the cycle after each strobe
    always @(negedge clk) wnext_seen = p1_wnext;
    always @(posedge clk) begin
        if (wnext_seen) begin
            #1;
            p1_wdata = wbase + 16'(wbeat);
            wbeat++;
        end
    end

    // Scoreboard monitor: grants and read beats popped and compared as they appear
    always @(negedge clk) begin
        if (!sdrc_rd_n) rd_lo_cnt++;
        if (!sdrc_wr_n) wr_lo_cnt++;
        if (p1_wnext) wnext_cnt++;
        if (p0_done) p0_done_cnt++;
        if (p1_done) p1_done_cnt++;
        if (p0_ack || p1_ack) begin
            ack_cnt++;
            if (exp_gnt_q.size() == 0) begin
                check("unexpected_ack", {p1_ack, p0_ack}, 32'd0);
            end else begin
                logic g;
                g = exp_gnt_q.pop_front();
                check("grant_port", {p1_ack, p0_ack}, g ? 32'd2 : 32'd1);
            end
        end
        if (p0_rvalid) begin
            rv_cnt++;
            if (exp_rd_q.size() == 0) begin
                check("unexpected_rvalid", 32'(p0_rvalid), 32'd0);
            end else begin
                beat_t b;
                b = exp_rd_q.pop_front();
                check("rdata", 32'(p0_rdata), 32'(b.data));
                check("rd_done_on_last", 32'(p0_done), 32'(b.last));
            end
        end
    end

    initial begin
        int n, rd0, wr0, wn0, rv0, ak0, d0, d1, gcount;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_strobes", {sdrc_wr_n, sdrc_rd_n}, 32'h3);
        check("rst_outs", {p0_ack, p0_rvalid, p0_done, p1_ack, p1_done, p1_wnext, timeout_err, sdrc_dqm}, 32'h0);
        check("rst_bus", {sdrc_addr, sdrc_data_len}, 32'h0);
        check("rst_wdata", 32'(sdrc_wdata), 32'h0);
        reset = 1'b0;

        // Requests ignored while the controller is initialising
        rd0 = rd_lo_cnt; ak0 = ack_cnt;
        p0_addr = 21'h55; p0_req = 1'b1;
        repeat (100) @(negedge clk);
        check("init_no_rd_n", rd_lo_cnt - rd0, 0);
        check("init_no_ack", ack_cnt - ak0, 0);
        p0_req = 1'b0; sdrc_init_done = 1'b1;
        repeat (3) @(negedge clk);

        // Port 0 read, 8 beats
        rd0 = rd_lo_cnt; rv0 = rv_cnt;
        push_read(21'h001000, 7); exp_gnt_q.push_back(PORT_RD);
        p0_addr = 21'h001000; p0_len = 8'd7; p0_req = 1'b1;
        wait_pulse(0, 20, "rd_ack", n);
        check("rd_cmd_addr", 32'(sdrc_addr), 32'h001000);
        check("rd_cmd_len", 32'(sdrc_data_len), 32'd7);
        p0_req = 1'b0;
        wait_pulse(2, 50, "rd_done", n);
        repeat (10) @(negedge clk);
        check("rd_one_strobe", rd_lo_cnt - rd0, 1);
        check("rd_beats", rv_cnt - rv0, 8);

        // Port 1 single-beat write at the top address
        wr0 = wr_lo_cnt; wn0 = wnext_cnt; d1 = p1_done_cnt;
        wbase = 16'hBEEF; wbeat = 0;
        exp_gnt_q.push_back(PORT_WR);
        p1_addr = 21'h1FFFFF; p1_len = 8'd0; p1_req = 1'b1;
        wait_pulse(1, 20, "wr_ack", n);
        check("wr_cmd_addr", 32'(sdrc_addr), 32'h1FFFFF);
        check("wr_wnext_in_cmd", 32'(p1_wnext), 32'd1);
        p1_req = 1'b0;
        wait_pulse(3, 50, "wr_done", n);
        check("wr_wdata", 32'(sdrc_wdata), 32'hBEEF);
        repeat (10) @(negedge clk);
        check("wr_one_strobe", wr_lo_cnt - wr0, 1);
        check("wr_one_wnext", wnext_cnt - wn0, 1);
        check("wr_one_done", p1_done_cnt - d1, 1);

        // Both ports held: starvation guard lets port 1 in every fifth grant
        p0_addr = 21'h000020; p0_len = 8'd0;
        p1_addr = 21'h000300; p1_len = 8'd0;
        for (int i = 0; i < 10; i++) begin
            exp_gnt_q.push_back((i % 5 == 4) ? PORT_WR : PORT_RD);
            if (i % 5 != 4) push_read(21'h000020, 0);
        end
        p0_req = 1'b1; p1_req = 1'b1;
        gcount = 0; n = 0;
        while (gcount < 10 && n < 400) begin
            @(negedge clk);
            n++;
            if (p0_ack || p1_ack) gcount++;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check("starve_grants", gcount, 10);
        repeat (15) @(negedge clk);
        check("starve_gnt_drained", exp_gnt_q.size(), 0);
        check("starve_rd_drained", exp_rd_q.size(), 0);

        // Controller never accepts: timeout after 255 cycles of waiting
        m_hang = 1'b1;
        exp_gnt_q.push_back(PORT_RD);
        p0_addr = 21'h000040; p0_len = 8'd0; p0_req = 1'b1;
        wait_pulse(0, 20, "to_ack", n);
        p0_req = 1'b0;
        repeat (200) @(negedge clk);
        check("to_not_yet", 32'(timeout_err), 32'd0);
        wait_pulse(2, 100, "to_done", n);
        check("to_latency", 200 + n, 256);
        check("to_err_set", 32'(timeout_err), 32'd1);
        m_hang = 1'b0;
        repeat (3) @(negedge clk);

        // Next request still served; error stays sticky
        wn0 = wnext_cnt; d1 = p1_done_cnt; wr0 = wr_lo_cnt;
        exp_gnt_q.push_back(PORT_WR);
        p1_addr = 21'h000100; p1_len = 8'd2; p1_req = 1'b1;
        wait_pulse(1, 20, "post_to_ack", n);
        p1_req = 1'b0;
        wait_pulse(3, 50, "post_to_done", n);
        repeat (10) @(negedge clk);
        check("post_to_wnext", wnext_cnt - wn0, 3);
        check("post_to_strobe", wr_lo_cnt - wr0, 1);
        check("post_to_done_cnt", p1_done_cnt - d1, 1);
        check("to_err_sticky", 32'(timeout_err), 32'd1);

        // Reset during the 4th beat of a 16-beat write
        d1 = p1_done_cnt;
        exp_gnt_q.push_back(PORT_WR);
        p1_addr = 21'h002000; p1_len = 8'd15; p1_req = 1'b1;
        wait_pulse(1, 20, "rst_wr_ack", n);
        p1_req = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_strobes", {sdrc_wr_n, sdrc_rd_n, p1_wnext, p1_done}, 32'hC);
        check("midrst_state", 32'(dut.state_q), 32'(INIT));
        check("midrst_timeout_clr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_done", p1_done_cnt - d1, 0);

        // Recovery read after reset
        d0 = p0_done_cnt;
        push_read(21'h000030, 1); exp_gnt_q.push_back(PORT_RD);
        p0_addr = 21'h000030; p0_len = 8'd1; p0_req = 1'b1;
        wait_pulse(0, 20, "rec_ack", n);
        p0_req = 1'b0;
        wait_pulse(2, 50, "rec_done", n);
        repeat (10) @(negedge clk);
        check("rec_done_cnt", p0_done_cnt - d0, 1);
        check("final_rd_q_empty", exp_rd_q.size(), 0);
        check("final_gnt_q_empty", exp_gnt_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
